// File: rtl/lfsr_symbol_gen.sv
// Bounded pseudo-random symbol generator: Fibonacci LFSR with rejection sampling,
// runtime seeding and a snapshot/restore shadow register for exact sequence replay.
module lfsr_symbol_gen #(
  parameter int                LFSR_W      = 7,
  parameter logic [LFSR_W-1:0] TAPS        = 7'b1010100,
  parameter logic [LFSR_W-1:0] SEED        = 7'b0000101,
  parameter int                OUT_W       = 2,
  parameter int                NUM_SYMBOLS = 3,
  parameter int                MAX_TRIES   = 4,
  parameter bit                FREE_RUN    = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed_in,
  input  logic              i_snap,
  input  logic              i_restore,
  output logic [OUT_W-1:0]  o_rand_out,
  output logic              o_rand_valid,
  output logic              o_busy,
  output logic [LFSR_W-1:0] o_lfsr_state
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]  MAX_TRIES_L = TW'(MAX_TRIES);
  localparam logic [OUT_W:0] NUM_SYM_L   = (OUT_W + 1)'(NUM_SYMBOLS);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SEARCH = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [TW-1:0]      r_tries, w_tries_nxt;
  logic [LFSR_W-1:0]  r_lfsr, w_lfsr_nxt;
  logic [LFSR_W-1:0]  r_shadow, w_shadow_nxt;
  logic [OUT_W-1:0]   r_rand_out, w_sym;
  logic               r_rand_valid, r_busy;
  logic               w_eval, w_deliver;
  logic [OUT_W-1:0]   w_cand;

  // An all-zero successor would lock the register up, so it is replaced by SEED.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = {s[LFSR_W-2:0], ^(s & TAPS)};
    return (n == {LFSR_W{1'b0}}) ? SEED : n;
  endfunction

  function automatic logic in_range(input logic [OUT_W-1:0] c);
    return ({1'b0, c} < NUM_SYM_L);
  endfunction

  function automatic logic [OUT_W-1:0] sym_mod(input logic [OUT_W-1:0] c);
    logic [OUT_W:0] m;
    m = {1'b0, c} % NUM_SYM_L;
    return m[OUT_W-1:0];
  endfunction

  assign w_cand = r_lfsr[OUT_W-1:0];

  // Request FSM: tries is 0 in IDLE, so one compare covers both states.
  always_comb begin
    w_state_nxt = r_state;
    w_tries_nxt = r_tries;
    w_deliver   = 1'b0;
    w_sym       = r_rand_out;
    case (r_state)
      S_IDLE:   w_eval = i_req;
      S_SEARCH: w_eval = 1'b1;
      default:  w_eval = 1'b0;
    endcase
    if (w_eval) begin
      if (in_range(w_cand)) begin
        w_deliver   = 1'b1;
        w_sym       = w_cand;
        w_state_nxt = S_IDLE;
        w_tries_nxt = {TW{1'b0}};
      end else if ((r_tries + TW'(1)) == MAX_TRIES_L) begin
        w_deliver   = 1'b1;
        w_sym       = sym_mod(w_cand);
        w_state_nxt = S_IDLE;
        w_tries_nxt = {TW{1'b0}};
      end else begin
        w_state_nxt = S_SEARCH;
        w_tries_nxt = r_tries + TW'(1);
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // LFSR source selection; the shadow always captures the pre-update state.
  always_comb begin
    if (i_seed_load) begin
      w_lfsr_nxt = (i_seed_in == {LFSR_W{1'b0}}) ? SEED : i_seed_in;
    end else if (i_restore) begin
      w_lfsr_nxt = r_shadow;
    end else if (FREE_RUN || w_eval) begin
      w_lfsr_nxt = lfsr_step(r_lfsr);
    end else begin
      w_lfsr_nxt = r_lfsr;
    end
    w_shadow_nxt = i_snap ? r_lfsr : r_shadow;
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_tries      <= {TW{1'b0}};
      r_lfsr       <= SEED;
      r_shadow     <= SEED;
      r_rand_out   <= {OUT_W{1'b0}};
      r_rand_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tries      <= w_tries_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_shadow     <= w_shadow_nxt;
      r_rand_out   <= w_sym;
      r_rand_valid <= w_deliver;
      r_busy       <= (w_state_nxt == S_SEARCH);
    end
  end

  assign o_rand_out   = r_rand_out;
  assign o_rand_valid = r_rand_valid;
  assign o_busy       = r_busy;
  assign o_lfsr_state = r_lfsr;

endmodule
